vga_scan: RTL
=============

VGA_SCAN -- requirements
Module: vga_scan

Interface
REQ-001 Parameter WIDTH, default 640, active pixels per line.
REQ-002 Parameter HEIGHT, default 480, active lines per frame.
REQ-003 Parameters H_FP/H_SYNC/H_BP, defaults 16/96/48; V_FP/V_SYNC/V_BP, defaults 10/2/33; totals H_TOT=800, V_TOT=525 at defaults.
REQ-004 Reset rst_n is asynchronous and active-low; clock is clk24.
REQ-005 clk24  in  1  pixel clock, all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 din  in  4  processed pixel from the output frame buffer's read port; synchronous RAM, valid the cycle after the address.
REQ-008 test_en  in  1  selects the colour-bar pattern instead of din.
REQ-009 addr_rd  out  19  frame-buffer read address.
REQ-010 vga_r, vga_g, vga_b  out  4 each  pixel colour.
REQ-011 hsync, vsync  out  1 each  sync pulses, active-low.
REQ-012 frame_start  out  1  one-cycle pulse aligned with output of pixel (0,0).

Function
REQ-013 Horizontal counter hc runs 0..H_TOT-1 and wraps to 0; at the wrap, vertical counter vc increments, wrapping 0..V_TOT-1.
REQ-014 Pixel (hc,vc) is active iff hc<WIDTH and vc<HEIGHT.
REQ-015 Raw hsync is low iff WIDTH+H_FP <= hc < WIDTH+H_FP+H_SYNC; raw vsync is low iff HEIGHT+V_FP <= vc < HEIGHT+V_FP+V_SYNC.
REQ-016 addr_rd is a registered incremental counter with no multiplier: after an active pixel it holds vc*WIDTH+hc of that pixel, and it is held during blanking.
REQ-017 The address counter returns to 0 when hc=H_TOT-1 and vc=V_TOT-1, so the first active pixel of each frame reads address 0.
REQ-018 Latency: counters at cycle t, addr_rd at t+1, din at t+2, and registered outputs (RGB, hsync, vsync, frame_start) at t+3; active, hsync and vsync are delayed through a matching 3-stage pipeline.
REQ-019 Active pixel with test_en latched low: vga_r = vga_g = vga_b = din.
REQ-020 Active pixel with test_en latched high: 8 bars, each WIDTH/8 wide, bar index = hc/(WIDTH/8) computed by a bar counter with no divider.
REQ-021 Bar colours, channel values 0xF or 0x0, in index order: white, yellow, cyan, green, magenta, red, blue, black.
REQ-022 Blanking pixels output RGB = 0 regardless of din and test_en.
REQ-023 test_en is sampled only when hc=H_TOT-1 and vc=V_TOT-1; a mid-frame change takes effect at the next frame.
REQ-024 frame_start is high for exactly one cycle per frame, in the cycle the RGB of pixel (0,0) is output.
REQ-025 din is ignored whenever the pipelined active flag is low.

Reset
REQ-026 While rst_n is low: hc=0, vc=0, addr_rd=0, RGB=0, hsync=1, vsync=1, frame_start=0, latched test_en=0, all pipeline stages cleared to inactive.
REQ-027 Reset asserted mid-frame aborts the frame; after release the scan restarts at (0,0) with no partial-line output.
REQ-028 The first frame_start after reset release occurs at cycle 3.

Verification
REQ-029 Release reset, run 2 frames -> hsync low 96 cycles per 800; vsync low 2 lines per 525; frame_start period 420000 cycles.
REQ-030 Model RAM with din = addr[3:0] -> active output RGB = (vc*640+hc)[3:0] 3 cycles after the counters; addr_rd maximum is 307199, then it wraps to 0.
REQ-031 test_en=1 before frame boundary -> line 0 pixels 0..79 are F/F/F, 80..159 are F/F/0, and 560..639 are 0/0/0.
REQ-032 Toggle test_en at line 100 -> no pattern change until next frame_start.
REQ-033 Drive din=0xF constantly -> RGB=0 at hc 640..799 and during lines 480..524.
REQ-034 Assert rst_n low at (hc=300, vc=200) for 5 cycles -> outputs at REQ-026 values; frame_start at cycle 3 after release, with addr_rd=0.

Source files
------------

// File: rtl/vga_scan_if.sv
// vga_scan_if -- signal bundle between the VGA scan generator and its environment.
//   din         : pixel from the frame buffer's synchronous read port (one cycle after addr_rd)
//   test_en     : request for the colour-bar pattern instead of din
//   addr_rd     : frame-buffer read address
//   vga_r/g/b   : pixel colour, 4 bits per channel
//   hsync/vsync : sync pulses, active-low
//   frame_start : one-cycle pulse aligned with the output of pixel (0,0)
// master = the scan generator, slave = frame buffer / display side.
interface vga_scan_if;
    logic [3:0]  din;
    logic        test_en;
    logic [18:0] addr_rd;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    modport master (
        input  din, test_en,
        output addr_rd, vga_r, vga_g, vga_b, hsync, vsync, frame_start
    );

    modport slave (
        output din, test_en,
        input  addr_rd, vga_r, vga_g, vga_b, hsync, vsync, frame_start
    );
endinterface

// File: rtl/vga_scan.sv
// vga_scan -- VGA raster scan generator with frame-buffer readout and colour-bar test pattern.
//   clk24 : pixel clock, rising edge
//   rst_n : asynchronous active-low reset
//   vif   : vga_scan_if.master (din/test_en in; addr_rd, RGB, syncs, frame_start out)
// Timing: counters at t, addr_rd at t+1, din at t+2, registered outputs at t+3.
module vga_scan #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic       clk24,
    input  logic       rst_n,
    vga_scan_if.master vif
);
    localparam int unsigned H_TOT = WIDTH + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = HEIGHT + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW    = $clog2(H_TOT);
    localparam int unsigned VW    = $clog2(V_TOT);
    localparam int unsigned BAR_W = WIDTH / 8;
    localparam int unsigned BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(WIDTH);
    localparam logic [HW-1:0] HS_BEG   = HW'(WIDTH + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(WIDTH + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(HEIGHT);
    localparam logic [VW-1:0] VS_BEG   = VW'(HEIGHT + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(HEIGHT + V_FP + V_SYNC);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [HW-1:0] hc_q, hc_d;
    logic [VW-1:0] vc_q, vc_d;
    logic [18:0]   addr_q, addr_d;
    logic [BW-1:0] bpos_q, bpos_d;
    logic [2:0]    bidx_q, bidx_d;
    logic          test_q, test_d;

    logic          frame_end, pix_act, hs_raw, vs_raw, fs_raw;

    // Pipeline stages 1 (t+1) and 2 (t+2); the output registers form stage 3.
    logic [1:0]    act_q, hs_q, vs_q, fs_q;
    logic [2:0]    bar1_q, bar2_q;

    logic [3:0]    r_q, g_q, b_q, r_d, g_d, b_d;
    logic          hsync_q, vsync_q, fstart_q;

    always_comb begin
        frame_end = (hc_q == H_LAST) && (vc_q == V_LAST);
        pix_act   = (hc_q < H_ACT) && (vc_q < V_ACT);
        hs_raw    = !((hc_q >= HS_BEG) && (hc_q < HS_END));
        vs_raw    = !((vc_q >= VS_BEG) && (vc_q < VS_END));
        fs_raw    = (hc_q == '0) && (vc_q == '0);

        hc_d   = hc_q + 1'b1;
        vc_d   = vc_q;
        bpos_d = bpos_q + 1'b1;
        bidx_d = bidx_q;
        addr_d = addr_q;
        test_d = test_q;

        // Bar index tracks hc/(WIDTH/8) with a position-within-bar counter.
        if (hc_q == H_LAST) begin
            hc_d   = '0;
            bpos_d = '0;
            bidx_d = '0;
            vc_d   = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
        end else if (bpos_q == BAR_LAST) begin
            bpos_d = '0;
            bidx_d = bidx_q + 1'b1;
        end

        // addr_rd holds the address of the most recent active pixel; pixel (0,0)
        // reuses the 0 loaded at the end of the previous frame.
        if (frame_end) begin
            addr_d = '0;
            test_d = vif.test_en;
        end else if (pix_act && !fs_raw) begin
            addr_d = addr_q + 1'b1;
        end

        // test_q only changes in vertical blanking, so using it at the output
        // stage cannot split a visible frame between sources.
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (act_q[1]) begin
            if (test_q) begin
                r_d = {4{~bar2_q[1]}};
                g_d = {4{~bar2_q[2]}};
                b_d = {4{~bar2_q[0]}};
            end else begin
                r_d = vif.din;
                g_d = vif.din;
                b_d = vif.din;
            end
        end
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            hc_q     <= '0;
            vc_q     <= '0;
            addr_q   <= '0;
            bpos_q   <= '0;
            bidx_q   <= '0;
            test_q   <= 1'b0;
            act_q    <= '0;
            hs_q     <= '1;
            vs_q     <= '1;
            fs_q     <= '0;
            bar1_q   <= '0;
            bar2_q   <= '0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            fstart_q <= 1'b0;
        end else begin
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            addr_q   <= addr_d;
            bpos_q   <= bpos_d;
            bidx_q   <= bidx_d;
            test_q   <= test_d;
            act_q    <= {act_q[0], pix_act};
            hs_q     <= {hs_q[0], hs_raw};
            vs_q     <= {vs_q[0], vs_raw};
            fs_q     <= {fs_q[0], fs_raw};
            bar1_q   <= bidx_q;
            bar2_q   <= bar1_q;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            hsync_q  <= hs_q[1];
            vsync_q  <= vs_q[1];
            fstart_q <= fs_q[1];
        end
    end

    assign vif.addr_rd     = addr_q;
    assign vif.vga_r       = r_q;
    assign vif.vga_g       = g_q;
    assign vif.vga_b       = b_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.frame_start = fstart_q;
endmodule
